// File: rtl/dmem_bus_bridge_if.sv
// Bus interfaces for dmem_bus_bridge: CPU data port, DMEM port and MMIO port.
// The "master" modport is the side that issues requests on that bus.

interface cpu_dbus_if;
  logic        cpu_cs;
  logic        cpu_w;
  logic        cpu_r;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_bits;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_fault;

  modport master (output cpu_cs, cpu_w, cpu_r, cpu_addr, cpu_wdata, cpu_bits,
                  input  cpu_rdata, cpu_stall, cpu_fault);
  modport slave  (input  cpu_cs, cpu_w, cpu_r, cpu_addr, cpu_wdata, cpu_bits,
                  output cpu_rdata, cpu_stall, cpu_fault);
endinterface

interface dm_bus_if #(parameter int AW = 11);
  logic          dm_cs;
  logic          dm_w;
  logic          dm_r;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [1:0]    dm_bits;
  logic [31:0]   dm_rdata;

  modport master (output dm_cs, dm_w, dm_r, dm_addr, dm_wdata, dm_bits,
                  input  dm_rdata);
  modport slave  (input  dm_cs, dm_w, dm_r, dm_addr, dm_wdata, dm_bits,
                  output dm_rdata);
endinterface

interface io_bus_if #(parameter int AW = 8);
  logic          io_req;
  logic          io_we;
  logic [AW-1:0] io_addr;
  logic [31:0]   io_wdata;
  logic [3:0]    io_be;
  logic [31:0]   io_rdata;
  logic          io_ready;

  modport master (output io_req, io_we, io_addr, io_wdata, io_be,
                  input  io_rdata, io_ready);
  modport slave  (input  io_req, io_we, io_addr, io_wdata, io_be,
                  output io_rdata, io_ready);
endinterface

// File: rtl/dmem_bus_bridge.sv
// Data-side bridge from the CPU data port to DMEM and an MMIO window, with DMEM
// wait states, MMIO ready/timeout and fault reporting. Optional: BRIDGE_ALIGN_CHECK_EN.

module dmem_bus_bridge #(
  parameter logic [31:0] DM_BASE    = 32'h1001_0000,
  parameter int          DM_AW      = 11,
  parameter logic [31:0] IO_BASE    = 32'h1002_0000,
  parameter int          IO_AW      = 8,
  parameter int          DM_WAIT    = 0,
  parameter int          IO_TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  cpu_dbus_if.slave   cpu,
  dm_bus_if.master    dm,
  io_bus_if.master    io
);

  typedef enum logic [1:0] {IDLE, DM_WAIT_S, IO_WAIT_S, RESP} state_t;

  localparam logic [3:0] DM_WAIT_M1    = 4'(DM_WAIT - 1);
  localparam logic [7:0] IO_TIMEOUT_M1 = 8'(IO_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        io_req_q, io_req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] dm_off, io_off;
  logic        dm_hit, io_hit, misalign, req;
  logic        is_byte, is_half;
  logic [1:0]  lo;
  logic [31:0] io_lane, io_rd_ext;
  logic [31:0] rdata_o;
  logic        stall_o, fault_o, dm_cs_o, dm_w_o, dm_r_o;

  assign dm_off = cpu.cpu_addr - DM_BASE;
  assign io_off = cpu.cpu_addr - IO_BASE;
  assign dm_hit = (cpu.cpu_addr >= DM_BASE) && ((dm_off >> DM_AW) == '0);
  assign io_hit = (cpu.cpu_addr >= IO_BASE) && ((io_off >> IO_AW) == '0);

  assign is_byte = (cpu.cpu_bits == 2'b10);
  assign is_half = (cpu.cpu_bits == 2'b01);
  // Lane offset of the access with the low bits dropped according to size.
  assign lo = is_byte ? cpu.cpu_addr[1:0] :
              is_half ? {cpu.cpu_addr[1], 1'b0} : 2'b00;

`ifdef BRIDGE_ALIGN_CHECK_EN
  assign misalign = (is_half && cpu.cpu_addr[0]) ||
                    (!is_byte && !is_half && (cpu.cpu_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Reset gates the combinational request path so nothing leaks out while held.
  assign req = cpu.cpu_cs && reset;

  assign io_lane   = io.io_rdata >> {lo, 3'b000};
  assign io_rd_ext = is_byte ? {24'h0, io_lane[7:0]} :
                     is_half ? {16'h0, io_lane[15:0]} : io_lane;

  assign dm.dm_addr  = DM_AW'({dm_off[31:2], lo});
  assign dm.dm_wdata = cpu.cpu_wdata;
  assign dm.dm_bits  = cpu.cpu_bits;
  assign dm.dm_cs    = dm_cs_o;
  assign dm.dm_w     = dm_w_o;
  assign dm.dm_r     = dm_r_o;

  assign io.io_req   = io_req_q;
  assign io.io_we    = cpu.cpu_w;
  assign io.io_addr  = IO_AW'({io_off[31:2], 2'b00});
  assign io.io_wdata = is_byte ? {4{cpu.cpu_wdata[7:0]}} :
                       is_half ? {2{cpu.cpu_wdata[15:0]}} : cpu.cpu_wdata;
  assign io.io_be    = is_byte ? (4'b0001 << lo) :
                       is_half ? (4'b0011 << lo) : 4'hF;

  assign cpu.cpu_rdata = rdata_o;
  assign cpu.cpu_stall = stall_o;
  assign cpu.cpu_fault = fault_o;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      io_req_q <= 1'b0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      io_req_q <= io_req_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  // cnt_q holds the stalled DMEM cycles still to go, counting the current one;
  // the request cycle itself is the first stalled cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    io_req_d = io_req_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    rdata_o  = '0;
    stall_o  = 1'b0;
    fault_o  = 1'b0;
    dm_cs_o  = 1'b0;
    dm_w_o   = 1'b0;
    dm_r_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if ((!dm_hit && !io_hit) || misalign) begin
            fault_o = 1'b1;
          end else if (dm_hit) begin
            dm_cs_o = 1'b1;
            dm_r_o  = cpu.cpu_r;
            if (DM_WAIT == 0) begin
              dm_w_o  = cpu.cpu_w;
              rdata_o = dm.dm_rdata;
            end else if (DM_WAIT == 1) begin
              dm_w_o  = cpu.cpu_w;
              stall_o = 1'b1;
              rdata_d = dm.dm_rdata;
              state_d = RESP;
            end else begin
              stall_o = 1'b1;
              cnt_d   = DM_WAIT_M1;
              state_d = DM_WAIT_S;
            end
          end else begin
            stall_o  = 1'b1;
            io_req_d = 1'b1;
            tcnt_d   = '0;
            state_d  = IO_WAIT_S;
          end
        end
      end

      DM_WAIT_S: begin
        stall_o = 1'b1;
        dm_cs_o = 1'b1;
        dm_r_o  = cpu.cpu_r;
        if (cnt_q == 4'd1) begin
          dm_w_o  = cpu.cpu_w;
          rdata_d = dm.dm_rdata;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      IO_WAIT_S: begin
        stall_o = 1'b1;
        tcnt_d  = tcnt_q + 8'd1;
        if (io.io_ready) begin
          rdata_d  = io_rd_ext;
          io_req_d = 1'b0;
          state_d  = RESP;
        end else if (tcnt_q == IO_TIMEOUT_M1) begin
          rdata_d  = '0;
          io_req_d = 1'b0;
          fault_d  = 1'b1;
          state_d  = RESP;
        end
      end

      RESP: begin
        rdata_o = rdata_q;
        fault_o = fault_q;
        fault_d = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
